// File: rtl/counter_wrap_capture_pkg.sv
// Shared definitions for the counter wrap/capture block: default sizing and
// the layout of a captured entry {wrap_cnt, cnt}.
package counter_defs;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_WRAP_W = 8;
   localparam int DEF_DEPTH  = 4;

   // Entry layout for the default sizing: wrap count in the upper field,
   // observed counter value in the lower field.
   localparam int ENTRY_W  = DEF_WRAP_W + DEF_WIDTH;
   localparam int WRAP_LSB = DEF_WIDTH;
   localparam int CNT_LSB  = 0;

endpackage

// File: rtl/capture_fifo_sync.sv
// Generic synchronous show-ahead FIFO. The head entry is held in a register
// so it stays valid (and keeps its last value) when the FIFO drains empty.
module capture_fifo_sync
   import counter_defs::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DATA_W = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE_LVL  = (AW + 1)'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_next;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_LVL);
   assign level   = count;
   assign rd_next = rd_ptr + 1'b1;

   // A pop frees a slot in the same cycle, so a push is accepted when full
   // as long as the head is leaving.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage write.
   // NOTE: the array is deliberately not reset; count and the pointers alone
   // decide which slots hold live data, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
   // NOTE: every sequential assignment uses <= so all registers update from
   // the same pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_next;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head register: refilled from the next slot on pop, from the incoming
   // entry when it becomes the head, otherwise held (also when draining empty).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (do_pop) begin
         if (count > ONE_LVL) begin
            dout <= mem[rd_next];
         end else if (do_push) begin
            dout <= din;
         end
      end else if (empty && do_push) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/counter_wrap_capture.sv
// Consumer of a free-running counter: counts its wrap-arounds, snapshots
// {wrap_cnt, cnt_in} on request into a FIFO, and drains it over valid/ready.
module counter_wrap_capture
   import counter_defs::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WRAP_W = DEF_WRAP_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           cnt_in,
   input  logic                       cnt_clr,
   input  logic                       cap_req,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WRAP_W+WIDTH-1:0]    out_data,
   output logic                       wrap_pulse,
   output logic                       ovf,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int ENT_W = WRAP_W + WIDTH;

   logic [WIDTH-1:0]  prev_cnt;
   logic [WRAP_W-1:0] wrap_cnt;
   logic [WRAP_W-1:0] wrap_cnt_next;
   logic              wrap;
   logic [ENT_W-1:0]  entry;
   logic              full;
   logic              empty;
   logic              pop;
   logic              push;

   // A wrap is all-ones followed by zero, unless the zero came from the
   // upstream counter being cleared.
   assign wrap = (prev_cnt == '1) && (cnt_in == '0) && !cnt_clr;

   // Next wrap count: clear wins over increment; increment wraps modulo 2^WRAP_W.
   // NOTE: the default assignment first keeps this combinational block from
   // inferring a latch on paths that do not otherwise assign it.
   always_comb begin
      wrap_cnt_next = wrap_cnt;
      if (cnt_clr) begin
         wrap_cnt_next = '0;
      end else if (wrap) begin
         wrap_cnt_next = wrap_cnt + 1'b1;
      end
   end

   // Entry carries the post-edge wrap count, so a same-cycle wrap or clear
   // is already reflected in the captured value.
   always_comb begin
      entry = '0;
      entry[WIDTH +: WRAP_W]   = wrap_cnt_next;
      entry[CNT_LSB +: WIDTH]  = cnt_in;
   end

   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign push      = cap_req && (!full || pop);

   // Wrap tracking, wrap pulse and sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_cnt   <= '0;
         wrap_cnt   <= '0;
         wrap_pulse <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         prev_cnt   <= cnt_in;
         wrap_cnt   <= wrap_cnt_next;
         wrap_pulse <= wrap;
         if (cap_req && full && !pop) begin
            ovf <= 1'b1;
         end
      end
   end

   capture_fifo_sync #(
      .DEPTH  (DEPTH),
      .DATA_W (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (entry),
      .dout  (out_data),
      .full  (full),
      .empty (empty),
      .level (level)
   );

endmodule

// File: tb/tb_counter_wrap_capture.sv
// Self-checking bench for counter_wrap_capture: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_counter_wrap_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cnt_in;
   logic        cnt_clr;
   logic        cap_req;
   logic        out_ready;
   logic        out_valid;
   logic [11:0] out_data;
   logic        wrap_pulse;
   logic        ovf;
   logic [2:0]  level;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int          m_prev;
   int          m_wc;
   logic [11:0] q[$];
   logic        m_ovf;
   logic        m_pulse;
   logic [11:0] m_head;

   counter_wrap_capture dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_in     (cnt_in),
      .cnt_clr    (cnt_clr),
      .cap_req    (cap_req),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .wrap_pulse (wrap_pulse),
      .ovf        (ovf),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural view: a bounded queue of snapshots, a wrap tally and flags.
   task automatic model_edge();
      bit pop;
      bit wrap;
      if (!rst_n) begin
         m_prev = 0; m_wc = 0; q.delete(); m_ovf = 1'b0; m_pulse = 1'b0; m_head = '0;
         return;
      end
      pop  = (q.size() > 0) && out_ready;
      wrap = (m_prev == 15) && (cnt_in == 4'd0) && !cnt_clr;
      if (cnt_clr)   m_wc = 0;
      else if (wrap) m_wc = (m_wc + 1) % 256;
      m_pulse = wrap;
      if (pop) void'(q.pop_front());
      if (cap_req) begin
         if (q.size() < 4) q.push_back({8'(m_wc), cnt_in});
         else              m_ovf = 1'b1;
      end
      m_prev = int'(cnt_in);
      if (q.size() > 0) m_head = q[0];
   endtask

   task automatic compare_all();
      check("out_valid",  32'(out_valid),  32'(q.size() > 0));
      check("level",      32'(level),      32'(q.size()));
      check("out_data",   32'(out_data),   32'(m_head));
      check("wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
      check("ovf",        32'(ovf),        32'(m_ovf));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic cyc(input logic r, input logic [3:0] c, input logic clr,
                      input logic cap, input logic rdy);
      rst_n = r; cnt_in = c; cnt_clr = clr; cap_req = cap; out_ready = rdy;
      step();
   endtask

   task automatic do_reset();
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [3:0] rc;
      rst_n = 1'b0; cnt_in = '0; cnt_clr = 1'b0; cap_req = 1'b1; out_ready = 1'b1;

      // 1. Reset with requests active
      cyc(1'b0, 4'd7, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 4'd7, 1'b0, 1'b1, 1'b1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);

      // 2. Count 0..15 then 0 with a capture on the wrap cycle
      for (int v = 0; v < 16; v++) cyc(1'b1, 4'(v), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      check("wrap_pulse_t2", 32'(wrap_pulse), 32'd1);
      check("wrap_data_t2",  32'(out_data), 32'h010);
      check("wrap_valid_t2", 32'(out_valid), 32'd1);
      cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);

      // 3. Clear on the zero cycle suppresses the wrap
      do_reset();
      cyc(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'd0,  1'b1, 1'b0, 1'b0);
      check("clr_no_pulse", 32'(wrap_pulse), 32'd0);
      cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
      check("clr_cap_data", 32'(out_data), 32'h003);

      // 4. Overfill then drain in order
      do_reset();
      for (int v = 1; v <= 5; v++) cyc(1'b1, 4'(v), 1'b0, 1'b1, 1'b0);
      check("ovf_level", 32'(level), 32'd4);
      check("ovf_set",   32'(ovf), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         check("drain_order", 32'(out_data[3:0]), 32'(i));
         cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      end
      check("drain_empty", 32'(out_valid), 32'd0);

      // 5. Full FIFO with simultaneous push and pop
      do_reset();
      for (int v = 1; v <= 4; v++) cyc(1'b1, 4'(v), 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 4'd5, 1'b0, 1'b1, 1'b1);
      check("pp_level", 32'(level), 32'd4);
      check("pp_ovf",   32'(ovf), 32'd0);
      check("pp_head",  32'(out_data[3:0]), 32'd2);

      // 6. 256 wraps, modulo wrap field, then reset with entries queued
      do_reset();
      for (int k = 0; k < 256; k++)
         for (int v = 0; v < 16; v++) cyc(1'b1, 4'(v), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      check("mod_wrap", 32'(out_data), 32'h000);
      cyc(1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
      check("pre_rst_level", 32'(level), 32'd3);
      cyc(1'b0, 4'd3, 1'b0, 1'b1, 1'b1);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_level", 32'(level), 32'd0);

      // Randomized traffic, mostly incrementing counter with occasional jumps
      rc = 4'd0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) rc = 4'($urandom_range(0, 15));
         else                           rc = rc + 4'd1;
         cyc(($urandom_range(0, 99) != 0),
             rc,
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
